counter_seq_ctrl: RTL and testbench

Sequencing controller for the two-digit up/down counter datapath and its shared 7-segment display.
- Turns raw start/direction/clear buttons into a run/pause/limit state machine.
- Paces the datapath with single-cycle step pulses from a prescaler, and owns the counting direction.
- Time-multiplexes the two digit enables with break-before-make blanking.

---
 rtl/counter_pkg.sv | 15 +
 rtl/tick_gen.sv | 37 +++
 rtl/counter_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the two-digit up/down counter controller.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LIMIT = 2'b11
    } state_t;

    localparam int COUNT_W       = 7;
    localparam int DEF_MAX_COUNT = 99;
    localparam int DEF_MIN_COUNT = 0;

endpackage

// File: rtl/tick_gen.sv
// Modulo-N counter with synchronous clear, hold enable and a one-cycle terminal pulse.
module tick_gen #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int             W    = $clog2(N);
    localparam logic [W-1:0]   ZERO = {W{1'b0}};
    localparam logic [W-1:0]   ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]   LAST = W'(N - 1);

    logic [W-1:0] count_r;
    logic         last_s;

    assign last_s = (count_r == LAST);
    // Clear dominates, so the terminal pulse never fires on a clearing cycle.
    assign tc     = en & ~clr & last_s;

    // Count register: clear, else advance with wrap, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= ZERO;
        end else if (clr) begin
            count_r <= ZERO;
        end else if (en) begin
            count_r <= last_s ? ZERO : (count_r + ONE);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run/pause/limit sequencer for the counter datapath plus digit scan with blanking.
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int SCAN_DIV  = 1000,
    parameter int MAX_COUNT = DEF_MAX_COUNT,
    parameter int MIN_COUNT = DEF_MIN_COUNT,
    parameter bit WRAP      = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               btn_dir,
    input  logic               btn_clr,
    input  logic [COUNT_W-1:0] count_val,
    output logic               cnt_step,
    output logic               cnt_ud,
    output logic               cnt_clr,
    output logic               digit1_ena,
    output logic               digit2_ena,
    output logic [1:0]         state
);

    localparam logic [COUNT_W-1:0] MAX_V = COUNT_W'(MAX_COUNT);
    localparam logic [COUNT_W-1:0] MIN_V = COUNT_W'(MIN_COUNT);

    state_t state_r, state_next_s;
    logic   ud_r, ud_next_s;
    logic   step_r, step_next_s;
    logic   clr_pulse_r;
    logic   start_prev_r, dir_prev_r, clr_prev_r;
    logic   start_edge_s, dir_edge_s, clr_edge_s;
    logic   step_clr_s, step_en_s, step_tc_s, at_limit_s;
    logic   scan_tc_s, slot_r, digit1_r, digit2_r;

    assign start_edge_s = btn_start & ~start_prev_r;
    assign dir_edge_s   = btn_dir   & ~dir_prev_r;
    assign clr_edge_s   = btn_clr   & ~clr_prev_r;

    // The step prescaler only advances in RUN, and freezes on the cycle a pause is requested.
    assign step_clr_s = clr_edge_s | (state_r == IDLE) | (state_r == LIMIT);
    assign step_en_s  = (state_r == RUN) & ~start_edge_s;
    assign at_limit_s = ud_r ? (count_val == MAX_V) : (count_val == MIN_V);

    tick_gen #(.N(TICK_DIV)) u_step_div (
        .clk   (clk),
        .reset (reset),
        .clr   (step_clr_s),
        .en    (step_en_s),
        .tc    (step_tc_s)
    );

    tick_gen #(.N(SCAN_DIV)) u_scan_div (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (1'b1),
        .tc    (scan_tc_s)
    );

    // Next-state, direction and step decode; a clear request overrides everything else.
    always_comb begin
        state_next_s = state_r;
        ud_next_s    = ud_r;
        step_next_s  = 1'b0;
        if (clr_edge_s) begin
            state_next_s = IDLE;
        end else begin
            if (dir_edge_s) begin
                ud_next_s = ~ud_r;
            end else begin
                ud_next_s = ud_r;
            end
            case (state_r)
                IDLE: begin
                    if (start_edge_s) state_next_s = RUN;
                    else              state_next_s = IDLE;
                end
                RUN: begin
                    if (start_edge_s) begin
                        state_next_s = PAUSE;
                    end else if (step_tc_s) begin
                        if (at_limit_s && (WRAP == 1'b0)) begin
                            state_next_s = LIMIT;
                        end else begin
                            state_next_s = RUN;
                            step_next_s  = 1'b1;
                        end
                    end else begin
                        state_next_s = RUN;
                    end
                end
                PAUSE: begin
                    if (start_edge_s) state_next_s = RUN;
                    else              state_next_s = PAUSE;
                end
                LIMIT: begin
                    if (dir_edge_s) state_next_s = RUN;
                    else            state_next_s = LIMIT;
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Sequencer registers; button history resets high so a held button is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            ud_r         <= 1'b1;
            step_r       <= 1'b0;
            clr_pulse_r  <= 1'b0;
            start_prev_r <= 1'b1;
            dir_prev_r   <= 1'b1;
            clr_prev_r   <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            ud_r         <= ud_next_s;
            step_r       <= step_next_s;
            clr_pulse_r  <= clr_edge_s;
            start_prev_r <= btn_start;
            dir_prev_r   <= btn_dir;
            clr_prev_r   <= btn_clr;
        end
    end

    // Digit scan: enables are decoded from the upcoming slot, blank whenever the slot wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_r   <= 1'b0;
            digit1_r <= 1'b0;
            digit2_r <= 1'b0;
        end else begin
            slot_r   <= slot_r ^ scan_tc_s;
            digit1_r <= ~scan_tc_s & ~slot_r;
            digit2_r <= ~scan_tc_s & slot_r;
        end
    end

    assign cnt_step   = step_r;
    assign cnt_ud     = ud_r;
    assign cnt_clr    = clr_pulse_r;
    assign digit1_ena = digit1_r;
    assign digit2_ena = digit2_r;
    assign state      = state_r;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Randomized and directed bench for counter_seq_ctrl (WRAP=0 and WRAP=1 instances side by side).
module tb_counter_seq_ctrl;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 3;
    localparam int MAXC     = 99;
    localparam int MINC     = 0;

    typedef struct {
        int mode;     // 0 idle, 1 run, 2 pause, 3 limit
        bit ud;
        int remain;   // running cycles left until the next due step
        bit step;
        bit clr;
        bit ps, pd, pc;
        int t;        // cycles since reset release
    } mdl_t;

    logic       clk = 1'b0;
    logic       reset, btn_start, btn_dir, btn_clr;
    logic [6:0] count_val;
    logic       step_o [2];
    logic       ud_o   [2];
    logic       clr_o  [2];
    logic       d1_o   [2];
    logic       d2_o   [2];
    logic [1:0] state_o[2];

    mdl_t m[2];
    bit   chk_en = 1'b0;
    int   ncmp   = 0;
    int   nfail  = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .MAX_COUNT(MAXC),
                       .MIN_COUNT(MINC), .WRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_dir(btn_dir),
        .btn_clr(btn_clr), .count_val(count_val), .cnt_step(step_o[0]), .cnt_ud(ud_o[0]),
        .cnt_clr(clr_o[0]), .digit1_ena(d1_o[0]), .digit2_ena(d2_o[0]), .state(state_o[0]));

    counter_seq_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .MAX_COUNT(MAXC),
                       .MIN_COUNT(MINC), .WRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_dir(btn_dir),
        .btn_clr(btn_clr), .count_val(count_val), .cnt_step(step_o[1]), .cnt_ud(ud_o[1]),
        .cnt_clr(clr_o[1]), .digit1_ena(d1_o[1]), .digit2_ena(d2_o[1]), .state(state_o[1]));

    function automatic mdl_t mdl_next(mdl_t m_in, bit wrap, bit rst, bit bs, bit bd, bit bc, int cv);
        mdl_t n;
        bit   se, de, ce, lim;
        n = m_in;
        if (rst) begin
            n.mode = 0; n.ud = 1'b1; n.remain = TICK_DIV; n.step = 1'b0; n.clr = 1'b0;
            n.ps = 1'b1; n.pd = 1'b1; n.pc = 1'b1; n.t = 0;
            return n;
        end
        se = bs && !m_in.ps;
        de = bd && !m_in.pd;
        ce = bc && !m_in.pc;
        n.ps = bs; n.pd = bd; n.pc = bc;
        n.step = 1'b0;
        n.clr  = 1'b0;
        n.t    = m_in.t + 1;
        if (ce) begin
            n.mode = 0; n.clr = 1'b1; n.remain = TICK_DIV;
        end else begin
            case (m_in.mode)
                0: if (se) begin n.mode = 1; n.remain = TICK_DIV; end
                1: begin
                    if (se) n.mode = 2;
                    else begin
                        n.remain = m_in.remain - 1;
                        if (n.remain == 0) begin
                            n.remain = TICK_DIV;
                            lim = m_in.ud ? (cv == MAXC) : (cv == MINC);
                            if (lim && !wrap) n.mode = 3;
                            else              n.step = 1'b1;
                        end
                    end
                end
                2: if (se) n.mode = 1;
                3: if (de) begin n.mode = 1; n.remain = TICK_DIV; end
                default: n.mode = 0;
            endcase
            if (de) n.ud = !m_in.ud;
        end
        return n;
    endfunction

    task automatic chk(input string name, input int inst, input int got, input int exp);
        ncmp++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", name, inst, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++)
            m[i] = mdl_next(m[i], (i == 1), reset, btn_start, btn_dir, btn_clr, int'(count_val));
        @(negedge clk);
    endtask

    // Every cycle: DUT outputs against the behavioural model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("state", i, int'(state_o[i]), m[i].mode);
                chk("ud", i, int'(ud_o[i]), int'(m[i].ud));
                chk("step", i, int'(step_o[i]), int'(m[i].step));
                chk("clr", i, int'(clr_o[i]), int'(m[i].clr));
                chk("digit1", i, int'(d1_o[i]),
                    int'((m[i].t % SCAN_DIV != 0) && ((m[i].t / SCAN_DIV) % 2 == 0)));
                chk("digit2", i, int'(d2_o[i]),
                    int'((m[i].t % SCAN_DIV != 0) && ((m[i].t / SCAN_DIV) % 2 == 1)));
                chk("both_ena", i, int'(d1_o[i] & d2_o[i]), 0);
                chk("step_and_clr", i, int'(step_o[i] & clr_o[i]), 0);
            end
        end
    end

    initial begin
        int d1_pat[12] = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        int d2_pat[12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
        reset = 1'b1; btn_start = 1'b1; btn_dir = 1'b0; btn_clr = 1'b0; count_val = 7'd5;

        // Reset held with start pressed.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_en = 1'b1;
            chk("rst_state", 0, int'(state_o[0]), 0);
            chk("rst_ud", 0, int'(ud_o[0]), 1);
            chk("rst_outs", 0, int'({step_o[0], clr_o[0], d1_o[0], d2_o[0]}), 0);
        end
        reset = 1'b0;

        // Scan pattern and idle hold from release.
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            chk("scan_d1", 0, int'(d1_o[0]), d1_pat[i]);
            chk("scan_d2", 0, int'(d2_o[0]), d2_pat[i]);
            chk("idle_hold", 0, int'(state_o[0]), 0);
        end

        // Start edge, then steps every TICK_DIV cycles.
        btn_start = 1'b0; tick();
        btn_start = 1'b1; tick();
        chk("run_entry", 0, int'(state_o[0]), 1);
        btn_start = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            chk("step_period", 0, int'(step_o[0]), int'(j % 4 == 0));
        end

        // Upper limit: WRAP=0 stops, WRAP=1 steps.
        count_val = 7'd99;
        for (int j = 0; j < 4; j++) tick();
        chk("limit_state", 0, int'(state_o[0]), 3);
        chk("limit_nostep", 0, int'(step_o[0]), 0);
        chk("wrap_step", 1, int'(step_o[1]), 1);
        chk("wrap_state", 1, int'(state_o[1]), 1);
        for (int j = 0; j < 20; j++) begin
            tick();
            chk("limit_quiet", 0, int'(step_o[0]), 0);
        end
        btn_dir = 1'b1; tick();
        chk("limit_rev_state", 0, int'(state_o[0]), 1);
        chk("limit_rev_ud", 0, int'(ud_o[0]), 0);
        btn_dir = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk("rev_step", 0, int'(step_o[0]), int'(j == 4));
        end

        // Lower limit while counting down.
        count_val = 7'd0;
        for (int j = 0; j < 4; j++) tick();
        chk("low_limit", 0, int'(state_o[0]), 3);
        chk("low_nostep", 0, int'(step_o[0]), 0);
        for (int j = 0; j < 3; j++) tick();
        chk("wrap_low_step", 1, int'(step_o[1]), 1);

        // Pause with prescaler at 2, resume.
        count_val = 7'd5;
        btn_dir = 1'b1; tick();
        chk("resume_run", 0, int'(state_o[0]), 1);
        btn_dir = 1'b0;
        tick(); tick();
        btn_start = 1'b1; tick();
        chk("pause_state", 0, int'(state_o[0]), 2);
        btn_start = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            chk("pause_quiet", 0, int'(step_o[0]), 0);
        end
        btn_start = 1'b1; tick();
        chk("unpause", 0, int'(state_o[0]), 1);
        btn_start = 1'b0;
        tick();
        chk("unpause_step1", 0, int'(step_o[0]), 0);
        tick();
        chk("unpause_step2", 0, int'(step_o[0]), 1);

        // Simultaneous clr/start/dir in RUN.
        btn_clr = 1'b1; btn_start = 1'b1; btn_dir = 1'b1; tick();
        chk("clr_state", 0, int'(state_o[0]), 0);
        chk("clr_pulse", 0, int'(clr_o[0]), 1);
        chk("clr_ud", 0, int'(ud_o[0]), 1);
        chk("clr_nostep", 0, int'(step_o[0]), 0);
        chk("clr_state", 1, int'(state_o[1]), 0);
        btn_clr = 1'b0; btn_start = 1'b0; btn_dir = 1'b0; tick();
        chk("clr_once", 0, int'(clr_o[0]), 0);

        // Random level toggles, values near the limits and occasional reset.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0)  btn_start = ~btn_start;
            if ($urandom_range(0, 9) == 0)  btn_dir   = ~btn_dir;
            if ($urandom_range(0, 39) == 0) btn_clr   = ~btn_clr;
            case ($urandom_range(0, 3))
                0:       count_val = 7'd0;
                1:       count_val = 7'd99;
                default: count_val = 7'($urandom_range(0, 127));
            endcase
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
